rgb_cmp_display: RTL and testbench
==================================

// Module: rgb_cmp_display
// PURPOSE
//  Clocked, parametrised successor to the 2-bit combinational RGB comparator lab block.
//  Compares two WIDTH-bit operands accepted over a valid/ready handshake, in unsigned or signed mode.
//  Latches the result and drives red (a>b), green (a==b) or blue (a<b) through a PWM brightness stage.
//  Each result stays displayed for a guaranteed minimum time. Sits between switch/UART operand capture and the board RGB LED.
// PARAMETERS
//  WIDTH        4   operand width in bits (>=2)
//  DUTY_W       8   PWM duty/counter width in bits
//  HOLD_CYCLES  16  minimum cycles a result is shown before the next is accepted (>=1)
// PORTS
//  clk          in   1       system clock; all logic in this single domain
//  rst_n        in   1       asynchronous active-low reset
//  a            in   WIDTH   operand A
//  b            in   WIDTH   operand B
//  signed_mode  in   1       1: two's-complement compare; 0: unsigned; sampled with a/b
//  in_valid     in   1       operands present
//  in_ready     out  1       block can accept operands this cycle
//  clear        in   1       synchronous: blank display, return to IDLE
//  duty         in   DUTY_W  LED brightness; 0 = off, all-ones = always on
//  cmp_res      out  2       latched result code (cmp_res_e)
//  res_valid    out  1       1 while a result is latched
//  red          out  1       LED drive, a>b
//  green        out  1       LED drive, a==b
//  blue         out  1       LED drive, a<b
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE, hold_cnt=0, pwm_cnt=0, cmp_res=CMP_NONE.
//   - res_valid=0, red=green=blue=0, in_ready=1.
//  Accept = in_valid && in_ready, evaluated at a rising edge.
//  FSM
//   - IDLE: in_ready=1. Accept -> SHOW; latch result from a/b/signed_mode; hold_cnt=HOLD_CYCLES-1.
//   - SHOW: in_ready = (hold_cnt==0). While hold_cnt!=0 it decrements every cycle.
//     Accept with hold_cnt==0 -> reload result and hold_cnt (back-to-back restart).
//     No input -> remain in SHOW indefinitely, result held.
//   - clear=1 in any state -> IDLE next edge; cmp_res=CMP_NONE; res_valid=0. clear has priority over accept.
//  Latency
//   - cmp_res/res_valid update on the accept edge and are visible the next cycle.
//   - LED outputs are registered: visible one cycle after cmp_res.
//  Compare
//   - Full-width, no truncation. Signed mode uses $signed on both operands.
//   - Result one-hot: exactly one of GT/EQ/LT.
//  PWM
//   - pwm_cnt free-runs 0..2^DUTY_W-1 and wraps; it is never reset by accept or clear.
//   - pwm_on = (duty=='1) ? 1 : (pwm_cnt < duty).
//   - LED = res_valid && one-hot bit && pwm_on.
//   - duty is sampled every cycle; a change takes effect within one cycle.
//  Boundaries
//   - HOLD_CYCLES=1: in_ready is 1 again the cycle after an accept.
//   - in_valid held high while in_ready=0: no accept, no state change.
//   - Reset asserted mid-SHOW: outputs go immediately to their reset values.
// STRUCTURE
//  Package rgb_cmp_pkg:
//   - typedef enum logic[1:0] cmp_res_e {CMP_NONE=0, CMP_GT=1, CMP_EQ=2, CMP_LT=3}
//   - typedef enum logic state_e {IDLE, SHOW}
//  Sub-module pwm_gen #(DUTY_W): clk, rst_n, duty -> pwm_on. Owns pwm_cnt; reused by later LED blocks.
//  Top: FSM, hold counter, compare logic and registered LED gating.
// TESTING (WIDTH=4, DUTY_W=8, HOLD_CYCLES=4 unless noted)
//  1. Unsigned: a=9,b=3 -> GT, red pulses. a=5,b=5 -> EQ, green. a=2,b=14 -> LT, blue.
//     With duty=8'hFF the LED is steadily 1.
//  2. Signed: a=4'b1000 (-8), b=4'b0001, signed_mode=1 -> LT, blue.
//     Same operands with signed_mode=0 -> GT, red.
//  3. Hold: in_valid held high continuously -> accepts exactly every 4 cycles.
//     in_ready low for 3 cycles after each accept.
//  4. PWM: duty=64, steady GT -> red high 64 of every 256 cycles. duty=0 -> red always 0.
//  5. clear asserted in the same cycle as a valid accept -> IDLE, res_valid=0, LEDs off.
//     Next accept is taken immediately.
//  6. rst_n pulsed low mid-SHOW -> all outputs reset asynchronously; in_ready=1 after release.

Source files
------------

// File: rtl/rgb_cmp_pkg.sv
// rtl/rgb_cmp_pkg.sv - shared result codes and FSM states for the RGB comparator display
package rgb_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_NONE = 2'd0,
        CMP_GT   = 2'd1,
        CMP_EQ   = 2'd2,
        CMP_LT   = 2'd3
    } cmp_res_e;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - free-running PWM counter and duty comparator for LED brightness
module pwm_gen #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_on
);

    logic [DUTY_W-1:0] pwm_cnt;

    // Counter is never restarted by the display logic so brightness phase is continuous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
        end
    end

    // All-ones means fully on, otherwise the top step of the period would stay dark.
    assign pwm_on = (duty == '1) ? 1'b1 : (pwm_cnt < duty);

endmodule

// File: rtl/rgb_cmp_display.sv
// rtl/rgb_cmp_display.sv - handshaked signed/unsigned comparator driving a held, PWM-dimmed RGB LED
module rgb_cmp_display
    import rgb_cmp_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DUTY_W      = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              signed_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    input  logic [DUTY_W-1:0] duty,
    output logic [1:0]        cmp_res,
    output logic              res_valid,
    output logic              red,
    output logic              green,
    output logic              blue
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_e            state;
    logic [HOLD_W-1:0] hold_cnt;
    cmp_res_e          res_q;
    cmp_res_e          res_d;
    logic              accept;
    logic              pwm_on;

    always_comb begin
        res_d = CMP_EQ;
        if (signed_mode) begin
            if ($signed(a) > $signed(b)) begin
                res_d = CMP_GT;
            end else if ($signed(a) < $signed(b)) begin
                res_d = CMP_LT;
            end
        end else begin
            if (a > b) begin
                res_d = CMP_GT;
            end else if (a < b) begin
                res_d = CMP_LT;
            end
        end
    end

    assign in_ready = (state == IDLE) || (hold_cnt == '0);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            res_q     <= CMP_NONE;
            res_valid <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            res_q     <= CMP_NONE;
            res_valid <= 1'b0;
        end else if (accept) begin
            state     <= SHOW;
            hold_cnt  <= HOLD_LOAD;
            res_q     <= res_d;
            res_valid <= 1'b1;
        end else if ((state == SHOW) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    assign cmp_res = res_q;

    pwm_gen #(
        .DUTY_W (DUTY_W)
    ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty   (duty),
        .pwm_on (pwm_on)
    );

    // LED drive is registered off the latched result, so it trails cmp_res by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else begin
            red   <= res_valid && (res_q == CMP_GT) && pwm_on;
            green <= res_valid && (res_q == CMP_EQ) && pwm_on;
            blue  <= res_valid && (res_q == CMP_LT) && pwm_on;
        end
    end

endmodule

// File: tb/tb_rgb_cmp_display.sv
// tb/tb_rgb_cmp_display.sv - randomized and directed bench for rgb_cmp_display against a cycle reference model
module tb_rgb_cmp_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       sm = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] duty = 8'hFF;

    logic [1:0] rdy, rv, r, g, bl;
    logic [1:0] cr0, cr1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;

    bit       m_valid [2];
    bit [1:0] m_res   [2];
    int       m_last  [2];
    bit [2:0] m_led   [2];

    always #5 clk = ~clk;

    rgb_cmp_display #(.WIDTH(4), .DUTY_W(8), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .signed_mode(sm),
        .in_valid(in_valid), .in_ready(rdy[0]), .clear(clear), .duty(duty),
        .cmp_res(cr0), .res_valid(rv[0]), .red(r[0]), .green(g[0]), .blue(bl[0])
    );

    rgb_cmp_display #(.WIDTH(4), .DUTY_W(8), .HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .signed_mode(sm),
        .in_valid(in_valid), .in_ready(rdy[1]), .clear(clear), .duty(duty),
        .cmp_res(cr1), .res_valid(rv[1]), .red(r[1]), .green(g[1]), .blue(bl[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int hold_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Result code from plain integer arithmetic: GT=1, EQ=2, LT=3.
    function automatic bit [1:0] ref_cmp(input logic [3:0] x, input logic [3:0] y, input logic s);
        int xi, yi;
        xi = int'(x);
        yi = int'(y);
        if (s) begin
            if (xi >= 8) xi -= 16;
            if (yi >= 8) yi -= 16;
        end
        return (xi > yi) ? 2'd1 : ((xi == yi) ? 2'd2 : 2'd3);
    endfunction

    function automatic bit m_ready(input int k);
        return !m_valid[k] || ((cyc_n - m_last[k]) >= hold_of(k));
    endfunction

    task automatic model_reset();
        cyc_n = 0;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_res[k]   = 2'd0;
            m_last[k]  = -1000;
            m_led[k]   = 3'b000;
        end
    endtask

    task automatic compare_all();
        logic [1:0] cr_k;
        for (int k = 0; k < 2; k++) begin
            cr_k = (k == 0) ? cr0 : cr1;
            check($sformatf("in_ready%0d", k), rdy[k], m_ready(k));
            check($sformatf("res_valid%0d", k), rv[k], m_valid[k]);
            check($sformatf("cmp_res%0d", k), cr_k, m_res[k]);
            check($sformatf("rgb%0d", k), {r[k], g[k], bl[k]}, m_led[k]);
        end
    endtask

    task automatic step();
        bit pon;
        bit rdy_k;
        @(posedge clk);
        pon = (duty == 8'hFF) || ((cyc_n % 256) < int'(duty));
        for (int k = 0; k < 2; k++) begin
            m_led[k] = (m_valid[k] && pon) ?
                       {m_res[k] == 2'd1, m_res[k] == 2'd2, m_res[k] == 2'd3} : 3'b000;
            rdy_k = m_ready(k);
            if (clear) begin
                m_valid[k] = 1'b0;
                m_res[k]   = 2'd0;
            end else if (in_valid && rdy_k) begin
                m_valid[k] = 1'b1;
                m_res[k]   = ref_cmp(a, b, sm);
                m_last[k]  = cyc_n;
            end
        end
        cyc_n++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [3:0] x, input logic [3:0] y, input logic s);
        a = x; b = y; sm = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic count_red(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            step();
            if (r[0]) hi++;
        end
    endtask

    initial begin
        int acc, low, hi;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Unsigned compares, full brightness
        duty = 8'hFF;
        send(4'd9, 4'd3, 1'b0);  step(); check("t1_gt_res", cr0, 2'd1); check("t1_gt_red", r[0], 1'b1);
        idle(3);
        send(4'd5, 4'd5, 1'b0);  step(); check("t1_eq_green", g[0], 1'b1);
        idle(3);
        send(4'd2, 4'd14, 1'b0); step(); check("t1_lt_blue", bl[0], 1'b1);
        idle(3);

        // Signed versus unsigned on the same operands
        send(4'b1000, 4'b0001, 1'b1); step(); check("t2_signed_lt", cr0, 2'd3);
        idle(3);
        send(4'b1000, 4'b0001, 1'b0); step(); check("t2_unsigned_gt", cr0, 2'd1);
        idle(3);

        // Continuous in_valid: accept once every hold window
        acc = 0; low = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 4'($urandom); b = 4'($urandom); sm = 1'($urandom);
            if (rdy[0]) acc++; else low++;
            step();
        end
        in_valid = 1'b0;
        check("t3_accepts", acc, 4);
        check("t3_ready_low", low, 12);
        idle(4);

        // PWM duty levels on a steady GT
        duty = 8'd64;
        send(4'd9, 4'd3, 1'b0);
        idle(3);
        count_red(256, hi); check("t4_duty64", hi, 64);
        duty = 8'd0;
        count_red(256, hi); check("t4_duty0", hi, 0);
        duty = 8'hFF;
        count_red(256, hi); check("t4_dutyff", hi, 256);

        // clear beats a simultaneous accept, next accept goes straight in
        a = 4'd5; b = 4'd5; sm = 1'b0; in_valid = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0;
        check("t5_cleared_valid", rv[0], 1'b0);
        check("t5_ready", rdy[0], 1'b1);
        step();
        check("t5_next_accept", cr0, 2'd2);
        idle(2);
        check("t5_leds_off_then_green", {r[0], g[0], bl[0]}, 3'b010);
        idle(4);

        // Reset mid-SHOW clears outputs without waiting for a clock edge
        send(4'd2, 4'd14, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t6_rdy%0d", k), rdy[k], 1'b1);
            check($sformatf("t6_rv%0d", k), rv[k], 1'b0);
            check($sformatf("t6_rgb%0d", k), {r[k], g[k], bl[k]}, 3'b000);
        end
        check("t6_cr0", cr0, 2'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            a        = 4'($urandom);
            b        = 4'($urandom);
            sm       = 1'($urandom);
            in_valid = ($urandom_range(0, 99) < 50);
            clear    = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 5) begin
                case ($urandom_range(0, 2))
                    0:       duty = 8'h00;
                    1:       duty = 8'hFF;
                    default: duty = 8'($urandom);
                endcase
            end
            step();
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
